// File: rtl/arbitro_pkg.sv
// Shared state encodings and index-width helper for the round-robin FIFO arbiter.
package arbitro_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ARB     = 2'b01;
  localparam logic [1:0] ST_BLOCKED = 2'b10;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arbitro_rr_pick.sv
// Single-cycle requester pick: round-robin from a pointer, or fixed lowest-index priority.
module rr_pick
  import arbitro_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter bit          RR_MODE = 1'b1,
  localparam int unsigned IW     = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] masked;
  int unsigned    base;

  // Doubling the request vector turns the wrap-around search into a linear one over [base, base+N).
  always_comb begin
    req2   = {req_i, req_i};
    base   = RR_MODE ? int'(ptr_i) : 0;
    masked = '0;
    for (int unsigned k = 0; k < 2*N; k++) begin
      masked[k] = req2[k] && (k >= base) && (k < base + N);
    end
  end

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int unsigned k = 0; k < 2*N; k++) begin
      if (masked[k] && !any_o) begin
        any_o = 1'b1;
        idx_o = IW'(k % N);
      end
    end
    gnt_o = '0;
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/arbitro_rr.sv
// Drains NUM_IN input FIFOs into NUM_OUT output FIFOs; pop is registered, push follows one cycle later.
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned NUM_OUT = 4,
  parameter bit          RR_MODE = 1'b1,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned SEL_W  = idx_w(NUM_IN),
  localparam int unsigned DEST_W = idx_w(NUM_OUT)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_IN-1:0]          empty_i,
  input  logic [NUM_IN*DEST_W-1:0]   head_dest_i,
  input  logic [NUM_OUT-1:0]         almost_full_i,
  output logic [NUM_IN-1:0]          pop_o,
  output logic [SEL_W-1:0]           select_o,
  output logic [NUM_OUT-1:0]         push_o,
  output logic [DEST_W-1:0]          dest_o,
  output logic [1:0]                 state_o,
  output logic [CNT_W-1:0]           blocked_cnt_o
);

  logic [DEST_W-1:0] dest_a [NUM_IN];
  logic [NUM_IN-1:0] elig;
  logic [NUM_IN-1:0] pick_gnt;
  logic [SEL_W-1:0]  pick_idx;
  logic              pick_any;

  logic [NUM_IN-1:0]  pop_q,      pop_d;
  logic [SEL_W-1:0]   pop_sel_q,  pop_sel_d;
  logic [DEST_W-1:0]  pop_dest_q, pop_dest_d;
  logic [NUM_OUT-1:0] push_q,     push_d;
  logic [SEL_W-1:0]   sel_q,      sel_d;
  logic [DEST_W-1:0]  dest_q,     dest_d;
  logic [SEL_W-1:0]   ptr_q,      ptr_d;
  logic [1:0]         state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;

  // Out-of-range destinations never match an almost_full bit, so they stay blocked.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      logic af_hit;
      dest_a[i] = head_dest_i[i*DEST_W +: DEST_W];
      af_hit    = 1'b1;
      for (int unsigned j = 0; j < NUM_OUT; j++) begin
        if (dest_a[i] == DEST_W'(j)) af_hit = almost_full_i[j];
      end
      elig[i] = !empty_i[i] && !af_hit && !pop_q[i];
    end
  end

  rr_pick #(
    .N       (NUM_IN),
    .RR_MODE (RR_MODE)
  ) u_pick (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    pop_d      = pick_any ? pick_gnt : '0;
    pop_sel_d  = pick_any ? pick_idx : pop_sel_q;
    pop_dest_d = pick_any ? dest_a[pick_idx] : pop_dest_q;

    ptr_d = ptr_q;
    if (RR_MODE && pick_any) begin
      ptr_d = (pick_idx == SEL_W'(NUM_IN - 1)) ? '0 : pick_idx + 1'b1;
    end

    push_d = '0;
    sel_d  = sel_q;
    dest_d = dest_q;
    if (|pop_q) begin
      push_d[pop_dest_q] = 1'b1;
      sel_d              = pop_sel_q;
      dest_d             = pop_dest_q;
    end

    if (&empty_i)      state_d = ST_IDLE;
    else if (pick_any) state_d = ST_ARB;
    else               state_d = ST_BLOCKED;

    if (state_d == ST_BLOCKED) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    else                       cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q      <= '0;
      pop_sel_q  <= '0;
      pop_dest_q <= '0;
      push_q     <= '0;
      sel_q      <= '0;
      dest_q     <= '0;
      ptr_q      <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
    end else begin
      pop_q      <= pop_d;
      pop_sel_q  <= pop_sel_d;
      pop_dest_q <= pop_dest_d;
      push_q     <= push_d;
      sel_q      <= sel_d;
      dest_q     <= dest_d;
      ptr_q      <= ptr_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pop_o         = pop_q;
  assign select_o      = sel_q;
  assign push_o        = push_q;
  assign dest_o        = dest_q;
  assign state_o       = state_q;
  assign blocked_cnt_o = cnt_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Randomized bench: a round-robin 4x4 instance and a fixed-priority 4x3 instance against a cycle model.
module tb_arbitro_rr;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] empty;
  logic [7:0] hdest;
  logic [3:0] af;

  logic [3:0] a_pop,  b_pop;
  logic [1:0] a_sel,  b_sel;
  logic [3:0] a_push;
  logic [2:0] b_push;
  logic [1:0] a_dest, b_dest;
  logic [1:0] a_st,   b_st;
  logic [7:0] a_cnt;
  logic [2:0] b_cnt;

  arbitro_rr #(
    .NUM_IN  (4),
    .NUM_OUT (4),
    .RR_MODE (1'b1),
    .CNT_W   (8)
  ) u_rr (
    .clk           (clk),
    .reset         (reset),
    .empty_i       (empty),
    .head_dest_i   (hdest),
    .almost_full_i (af),
    .pop_o         (a_pop),
    .select_o      (a_sel),
    .push_o        (a_push),
    .dest_o        (a_dest),
    .state_o       (a_st),
    .blocked_cnt_o (a_cnt)
  );

  arbitro_rr #(
    .NUM_IN  (4),
    .NUM_OUT (3),
    .RR_MODE (1'b0),
    .CNT_W   (3)
  ) u_fp (
    .clk           (clk),
    .reset         (reset),
    .empty_i       (empty),
    .head_dest_i   (hdest),
    .almost_full_i (af[2:0]),
    .pop_o         (b_pop),
    .select_o      (b_sel),
    .push_o        (b_push),
    .dest_o        (b_dest),
    .state_o       (b_st),
    .blocked_cnt_o (b_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: index 0 = round-robin 4 outputs, index 1 = fixed priority 3 outputs.
  int NOUT [2] = '{4, 3};
  bit RRM  [2] = '{1'b1, 1'b0};
  int CMAX [2] = '{255, 7};

  int m_pop [2];  // input popped this cycle, -1 none
  int m_pd  [2];  // destination carried by that pop
  int m_push[2];  // output pushed this cycle, -1 none
  int m_sel [2];
  int m_dest[2];
  int m_st  [2];
  int m_cnt [2];
  int m_ptr [2];

  task automatic model_step(input int m);
    int  dst [4];
    bit  elig[4];
    int  g;
    if (reset) begin
      m_pop[m] = -1; m_pd[m] = 0; m_push[m] = -1; m_sel[m] = 0;
      m_dest[m] = 0; m_st[m] = 0; m_cnt[m] = 0; m_ptr[m] = 0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      dst[i]  = int'(hdest[i*2 +: 2]);
      elig[i] = !empty[i] && (dst[i] < NOUT[m]) && !af[dst[i]] && (m_pop[m] != i);
    end
    g = -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = RRM[m] ? (m_ptr[m] + k) % 4 : k;
      if (g < 0 && elig[i]) g = i;
    end
    if (m_pop[m] >= 0) begin
      m_push[m] = m_pd[m];
      m_sel[m]  = m_pop[m];
      m_dest[m] = m_pd[m];
    end else begin
      m_push[m] = -1;
    end
    if (empty == 4'hF) m_st[m] = 0;
    else if (g >= 0)   m_st[m] = 1;
    else               m_st[m] = 2;
    if (m_st[m] == 2) m_cnt[m] = (m_cnt[m] < CMAX[m]) ? m_cnt[m] + 1 : m_cnt[m];
    else              m_cnt[m] = 0;
    m_pop[m] = g;
    if (g >= 0) begin
      m_pd[m] = dst[g];
      if (RRM[m]) m_ptr[m] = (g + 1) % 4;
    end
  endtask

  function automatic logic [31:0] onehot(input int idx);
    return (idx < 0) ? 32'd0 : (32'd1 << idx);
  endfunction

  task automatic check_all();
    check_eq("rr.pop",   a_pop,  onehot(m_pop[0]));
    check_eq("rr.push",  a_push, onehot(m_push[0]));
    check_eq("rr.sel",   a_sel,  m_sel[0]);
    check_eq("rr.dest",  a_dest, m_dest[0]);
    check_eq("rr.state", a_st,   m_st[0]);
    check_eq("rr.cnt",   a_cnt,  m_cnt[0]);
    check_eq("fp.pop",   b_pop,  onehot(m_pop[1]));
    check_eq("fp.push",  b_push, onehot(m_push[1]));
    check_eq("fp.sel",   b_sel,  m_sel[1]);
    check_eq("fp.dest",  b_dest, m_dest[1]);
    check_eq("fp.state", b_st,   m_st[1]);
    check_eq("fp.cnt",   b_cnt,  m_cnt[1]);
  endtask

  initial begin
    reset = 1'b1;
    empty = 4'h0;
    hdest = 8'hE4;
    af    = 4'h0;
    model_step(0);
    model_step(1);
    for (int cyc = 0; cyc < 1600; cyc++) begin
      int seg;
      int ph;
      @(negedge clk);
      check_all();
      seg = (cyc / 100) % 4;
      ph  = cyc % 100;
      if (cyc < 2) begin
        reset = 1'b1;
        empty = 4'h0;
        hdest = 8'hE4;
        af    = 4'h0;
      end else if (cyc < 12) begin
        reset = 1'b0;
        empty = 4'h0;
        hdest = 8'hE4;
        af    = 4'h0;
      end else begin
        reset = ($urandom_range(99) == 0) && !(seg == 3 && ph < 20);
        hdest = 8'($urandom);
        case (seg)
          0: begin
            for (int i = 0; i < 4; i++) empty[i] = ($urandom_range(4) == 0);
            af = ($urandom_range(7) == 0) ? 4'($urandom) : 4'h0;
          end
          1: begin
            empty = 4'hF;
            if ($urandom_range(2) != 0) empty[$urandom_range(3)] = 1'b0;
            af = 4'h0;
          end
          2: begin
            empty = 4'($urandom);
            af    = 4'($urandom);
          end
          default: begin
            if (ph < 20) begin
              empty = 4'h0;
              af    = 4'hF;
            end else begin
              empty = 4'($urandom);
              af    = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
            end
          end
        endcase
      end
      model_step(0);
      model_step(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
